// File: rtl/pmem_arbiter.sv
// ---------------------------------------------------------------------------
// pmem_arbiter
//
// Shares one physical-memory port between NUM_CH requesting channels. One
// transaction is outstanding at a time. A two-state FSM (IDLE/BUSY) picks a
// winner in IDLE, latches its op/address/data, and drives the memory request
// from those registers while BUSY. The channels are arbitrated round-robin or
// by fixed priority (channel 0 highest).
//
// Parameters
//   NUM_CH      number of requesting channels (2..8)
//   ADDR_WIDTH  physical address width
//   LINE_WIDTH  line data width
//   FIXED_PRIO  0 = round-robin, 1 = fixed priority
//
// Ports
//   clk, rst_n           clock and synchronous active-low reset
//   ch_read / ch_write   per-channel level requests, held until ch_resp
//   ch_address/ch_wdata  flattened per-channel address / write data
//   ch_resp              one-hot completion pulse to the granted channel
//   ch_rdata             memory read data broadcast to all channels
//   pmem_*               memory-side request / response
//   grant_id             index of the channel owning memory
//   busy                 high while a transaction is outstanding
// ---------------------------------------------------------------------------
module pmem_arbiter #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int FIXED_PRIO = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              ch_read,
    input  logic [NUM_CH-1:0]              ch_write,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_address,
    input  logic [NUM_CH*LINE_WIDTH-1:0]   ch_wdata,
    output logic [NUM_CH-1:0]              ch_resp,
    output logic [LINE_WIDTH-1:0]          ch_rdata,
    output logic                           pmem_read,
    output logic                           pmem_write,
    output logic [ADDR_WIDTH-1:0]          pmem_address,
    output logic [LINE_WIDTH-1:0]          pmem_wdata,
    input  logic                           pmem_resp,
    input  logic [LINE_WIDTH-1:0]          pmem_rdata,
    output logic [$clog2(NUM_CH)-1:0]      grant_id,
    output logic                           busy
);

    localparam int ID_W = $clog2(NUM_CH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [NUM_CH-1:0]   req;
    logic                win_valid;
    logic [ID_W-1:0]     win_id;
    logic                sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LINE_WIDTH-1:0] sel_wdata;

    assign req = ch_read | ch_write;

    // Winner selection. Round-robin walks outward from rr_ptr+1 so the last
    // granted channel has lowest priority; the nested loop keeps every vector
    // index a compile-time constant after unrolling.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        if (FIXED_PRIO != 0) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    win_valid = 1'b1;
                    win_id    = ID_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= NUM_CH; k++) begin
                for (int j = 0; j < NUM_CH; j++) begin
                    if (!win_valid && req[j] &&
                        (j == ((int'(rr_ptr) + k) % NUM_CH))) begin
                        win_valid = 1'b1;
                        win_id    = ID_W'(j);
                    end
                end
            end
        end
    end

    // Mux the winning channel's op, address and data. A channel raising both
    // read and write is treated as a write.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (win_id == ID_W'(j)) begin
                sel_write = ch_write[j];
                sel_addr  = ch_address[j*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = ch_wdata[j*LINE_WIDTH +: LINE_WIDTH];
            end
        end
    end

    // Main FSM. All memory-side outputs are registered at grant time and held
    // through BUSY, so channel inputs moving mid-transaction have no effect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            busy         <= 1'b0;
            grant_id     <= '0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            rr_ptr       <= ID_W'(NUM_CH - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state        <= BUSY;
                        busy         <= 1'b1;
                        grant_id     <= win_id;
                        rr_ptr       <= win_id;
                        pmem_address <= sel_addr;
                        pmem_wdata   <= sel_wdata;
                        pmem_write   <= sel_write;
                        pmem_read    <= ~sel_write;
                    end
                end
                BUSY: begin
                    if (pmem_resp) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Completion is combinational from pmem_resp so the channel sees it in the
    // same cycle; a response arriving in IDLE (e.g. after a reset) is dropped.
    always_comb begin
        ch_resp = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            ch_resp[j] = (state == BUSY) && pmem_resp && (grant_id == ID_W'(j));
        end
    end

    assign ch_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pmem_arbiter
//
// Directed bench for pmem_arbiter. Instance "a" is the default 2-channel
// round-robin configuration; instance "b" is a 4-channel fixed-priority
// configuration. Inputs change and outputs are sampled 1 time unit after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_pmem_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;

    logic clk = 1'b0;
    logic rst_n;

    // instance a: NUM_CH=2, round-robin
    logic [1:0]      a_ch_read, a_ch_write, a_ch_resp;
    logic [2*AW-1:0] a_ch_address;
    logic [2*LW-1:0] a_ch_wdata;
    logic [LW-1:0]   a_ch_rdata, a_pmem_wdata, a_pmem_rdata;
    logic            a_pmem_read, a_pmem_write, a_pmem_resp, a_busy;
    logic [AW-1:0]   a_pmem_address;
    logic [0:0]      a_grant_id;

    // instance b: NUM_CH=4, fixed priority
    logic [3:0]      b_ch_read, b_ch_write, b_ch_resp;
    logic [4*AW-1:0] b_ch_address;
    logic [4*LW-1:0] b_ch_wdata;
    logic [LW-1:0]   b_ch_rdata, b_pmem_wdata, b_pmem_rdata;
    logic            b_pmem_read, b_pmem_write, b_pmem_resp, b_busy;
    logic [AW-1:0]   b_pmem_address;
    logic [1:0]      b_grant_id;

    int checks = 0;
    int errors = 0;

    pmem_arbiter #(.NUM_CH(2), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .FIXED_PRIO(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .ch_read(a_ch_read), .ch_write(a_ch_write),
        .ch_address(a_ch_address), .ch_wdata(a_ch_wdata),
        .ch_resp(a_ch_resp), .ch_rdata(a_ch_rdata),
        .pmem_read(a_pmem_read), .pmem_write(a_pmem_write),
        .pmem_address(a_pmem_address), .pmem_wdata(a_pmem_wdata),
        .pmem_resp(a_pmem_resp), .pmem_rdata(a_pmem_rdata),
        .grant_id(a_grant_id), .busy(a_busy)
    );

    pmem_arbiter #(.NUM_CH(4), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .FIXED_PRIO(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .ch_read(b_ch_read), .ch_write(b_ch_write),
        .ch_address(b_ch_address), .ch_wdata(b_ch_wdata),
        .ch_resp(b_ch_resp), .ch_rdata(b_ch_rdata),
        .pmem_read(b_pmem_read), .pmem_write(b_pmem_write),
        .pmem_address(b_pmem_address), .pmem_wdata(b_pmem_wdata),
        .pmem_resp(b_pmem_resp), .pmem_rdata(b_pmem_rdata),
        .grant_id(b_grant_id), .busy(b_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_ch_read = '0; a_ch_write = '0; a_ch_address = '0; a_ch_wdata = '0;
        a_pmem_resp = 1'b0; a_pmem_rdata = '0;
        b_ch_read = '0; b_ch_write = '0; b_ch_wdata = '0;
        b_ch_address = {16'h3040, 16'h2040, 16'h1040, 16'h0040};
        b_pmem_resp = 1'b0; b_pmem_rdata = '0;
        tick();
        tick();
        checks++;
        if ({a_busy, a_pmem_read, a_pmem_write, a_grant_id, a_ch_resp} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl_a got %b exp 000000",
                     {a_busy, a_pmem_read, a_pmem_write, a_grant_id, a_ch_resp});
        end
        checks++;
        if ({a_pmem_address, a_pmem_wdata} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data_a got addr %h wdata %h exp 0", a_pmem_address, a_pmem_wdata);
        end
        checks++;
        if ({b_busy, b_pmem_read, b_pmem_write, b_grant_id, b_pmem_address} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_b got busy %b rd %b wr %b gid %0d addr %h exp all 0",
                     b_busy, b_pmem_read, b_pmem_write, b_grant_id, b_pmem_address);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        a_ch_read = 2'b01;
        a_ch_address = {16'h0000, 16'h1230};
        tick();
        checks++;
        if ({a_busy, a_pmem_read, a_pmem_write, a_grant_id} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL read_issue got busy/rd/wr/gid %b exp 1100",
                     {a_busy, a_pmem_read, a_pmem_write, a_grant_id});
        end
        checks++;
        if (a_pmem_address !== 16'h1230) begin
            errors++;
            $display("[TB] FAIL read_addr got %h exp 1230", a_pmem_address);
        end
        a_ch_address = {16'h0000, 16'h7777};
        tick();
        tick();
        checks++;
        if (a_pmem_address !== 16'h1230 || a_ch_resp !== 2'b00) begin
            errors++;
            $display("[TB] FAIL read_hold got addr %h resp %b exp 1230 00", a_pmem_address, a_ch_resp);
        end
        a_pmem_resp = 1'b1;
        a_pmem_rdata = {16{8'hA5}};
        a_ch_read = 2'b00;
        #1;
        checks++;
        if (a_ch_resp !== 2'b01) begin
            errors++;
            $display("[TB] FAIL read_resp got %b exp 01", a_ch_resp);
        end
        checks++;
        if (a_ch_rdata !== {16{8'hA5}}) begin
            errors++;
            $display("[TB] FAIL read_rdata got %h exp a5..a5", a_ch_rdata);
        end
        tick();
        a_pmem_resp = 1'b0;
        #1;
        checks++;
        if ({a_busy, a_pmem_read, a_ch_resp} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL read_done got busy/rd/resp %b exp 0000", {a_busy, a_pmem_read, a_ch_resp});
        end
    endtask

    task automatic test_write();
        a_ch_write = 2'b10;
        a_ch_read = 2'b10;
        a_ch_address = {16'hBEE0, 16'h0000};
        a_ch_wdata = {{8{16'hDEAD}}, {8{16'h0000}}};
        tick();
        checks++;
        if ({a_busy, a_pmem_read, a_pmem_write, a_grant_id} !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL write_issue got busy/rd/wr/gid %b exp 1011",
                     {a_busy, a_pmem_read, a_pmem_write, a_grant_id});
        end
        checks++;
        if (a_pmem_address !== 16'hBEE0 || a_pmem_wdata !== {8{16'hDEAD}}) begin
            errors++;
            $display("[TB] FAIL write_data got addr %h wdata %h exp bee0 dead..", a_pmem_address, a_pmem_wdata);
        end
        a_pmem_resp = 1'b1;
        a_ch_write = 2'b00;
        a_ch_read = 2'b00;
        #1;
        checks++;
        if (a_ch_resp !== 2'b10) begin
            errors++;
            $display("[TB] FAIL write_resp got %b exp 10", a_ch_resp);
        end
        tick();
        a_pmem_resp = 1'b0;
    endtask

    task automatic test_resp_in_idle();
        a_pmem_resp = 1'b1;
        #1;
        checks++;
        if (a_ch_resp !== 2'b00) begin
            errors++;
            $display("[TB] FAIL idle_resp got %b exp 00", a_ch_resp);
        end
        tick();
        a_pmem_resp = 1'b0;
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_busy got %b exp 0", a_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:0] exp_gid;
        a_ch_read = 2'b11;
        a_ch_address = {16'h2222, 16'h1111};
        for (int n = 0; n < 4; n++) begin
            exp_gid = n[0];
            tick();
            checks++;
            if (a_grant_id !== exp_gid || a_pmem_read !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rr_grant%0d got gid %0d rd %b exp gid %0d rd 1", n, a_grant_id, a_pmem_read, exp_gid);
            end
            tick();
            a_pmem_resp = 1'b1;
            if (n == 3) a_ch_read = 2'b00;
            #1;
            checks++;
            if (a_ch_resp !== (2'b01 << exp_gid)) begin
                errors++;
                $display("[TB] FAIL rr_resp%0d got %b exp %b", n, a_ch_resp, 2'b01 << exp_gid);
            end
            tick();
            a_pmem_resp = 1'b0;
            #1;
            checks++;
            if ({a_pmem_read, a_pmem_write, a_ch_resp} !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL rr_gap%0d got rd/wr/resp %b exp 0000", n, {a_pmem_read, a_pmem_write, a_ch_resp});
            end
        end
    endtask

    task automatic test_drop_during_busy();
        a_ch_read = 2'b01;
        tick();
        a_ch_read = 2'b00;
        checks++;
        if (a_grant_id !== 1'b0 || a_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drop_grant got gid %0d busy %b exp 0 1", a_grant_id, a_busy);
        end
        tick();
        checks++;
        if (a_busy !== 1'b1 || a_pmem_read !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drop_hold got busy %b rd %b exp 1 1", a_busy, a_pmem_read);
        end
        a_pmem_resp = 1'b1;
        #1;
        checks++;
        if (a_ch_resp !== 2'b01) begin
            errors++;
            $display("[TB] FAIL drop_resp got %b exp 01", a_ch_resp);
        end
        tick();
        a_pmem_resp = 1'b0;
    endtask

    task automatic test_reset_busy();
        a_ch_read = 2'b01;
        tick();
        a_ch_read = 2'b00;
        checks++;
        if (a_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstbusy_pre got busy %b exp 1", a_busy);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({a_busy, a_pmem_read, a_pmem_write, a_grant_id} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL rstbusy_state got busy/rd/wr/gid %b exp 0000",
                     {a_busy, a_pmem_read, a_pmem_write, a_grant_id});
        end
        a_pmem_resp = 1'b1;
        #1;
        checks++;
        if (a_ch_resp !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rstbusy_resp got %b exp 00", a_ch_resp);
        end
        tick();
        a_pmem_resp = 1'b0;
        a_ch_read = 2'b11;
        tick();
        checks++;
        if (a_grant_id !== 1'b0 || a_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstbusy_next got gid %0d busy %b exp 0 1", a_grant_id, a_busy);
        end
        a_pmem_resp = 1'b1;
        a_ch_read = 2'b00;
        tick();
        a_pmem_resp = 1'b0;
    endtask

    task automatic test_fixed_prio();
        b_ch_read = 4'b1010;
        tick();
        checks++;
        if (b_grant_id !== 2'd1 || b_pmem_address !== 16'h1040) begin
            errors++;
            $display("[TB] FAIL fp_first got gid %0d addr %h exp 1 1040", b_grant_id, b_pmem_address);
        end
        tick();
        b_pmem_resp = 1'b1;
        b_ch_read = 4'b1000;
        #1;
        checks++;
        if (b_ch_resp !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL fp_resp1 got %b exp 0010", b_ch_resp);
        end
        tick();
        b_pmem_resp = 1'b0;
        tick();
        checks++;
        if (b_grant_id !== 2'd3 || b_pmem_address !== 16'h3040) begin
            errors++;
            $display("[TB] FAIL fp_second got gid %0d addr %h exp 3 3040", b_grant_id, b_pmem_address);
        end
        b_pmem_resp = 1'b1;
        b_ch_read = 4'b1010;
        #1;
        checks++;
        if (b_ch_resp !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL fp_resp3 got %b exp 1000", b_ch_resp);
        end
        tick();
        b_pmem_resp = 1'b0;
        tick();
        b_pmem_resp = 1'b1;
        tick();
        b_pmem_resp = 1'b0;
        tick();
        // channel 1 kept requesting after its completion, so it wins again
        checks++;
        if (b_grant_id !== 2'd1) begin
            errors++;
            $display("[TB] FAIL fp_repeat got gid %0d exp 1", b_grant_id);
        end
        b_pmem_resp = 1'b1;
        b_ch_read = 4'b0000;
        tick();
        b_pmem_resp = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_resp_in_idle();
        test_back_to_back();
        test_drop_during_busy();
        test_reset_busy();
        test_fixed_prio();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of requesting channels (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, physical address width.
REQ-003 SHALL have parameter LINE_WIDTH, default 128, line data width.
REQ-004 SHALL have parameter FIXED_PRIO, default 0; 0 = round-robin, 1 = fixed priority with channel 0 highest.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port ch_read  input  NUM_CH  per-channel read request, level, held until ch_resp.
REQ-008 SHALL have port ch_write  input  NUM_CH  per-channel write request, level, held until ch_resp.
REQ-009 SHALL have port ch_address  input  NUM_CH*ADDR_WIDTH  flattened addresses; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL have port ch_wdata  input  NUM_CH*LINE_WIDTH  flattened write data, same packing.
REQ-011 SHALL have port ch_resp  output  NUM_CH  one-hot completion pulse.
REQ-012 SHALL have port ch_rdata  output  LINE_WIDTH  read data, broadcast to all channels.
REQ-013 SHALL have port pmem_read  output  1  memory read request.
REQ-014 SHALL have port pmem_write  output  1  memory write request.
REQ-015 SHALL have port pmem_address  output  ADDR_WIDTH  memory address.
REQ-016 SHALL have port pmem_wdata  output  LINE_WIDTH  memory write data.
REQ-017 SHALL have port pmem_resp  input  1  memory completion, one-cycle pulse.
REQ-018 SHALL have port pmem_rdata  input  LINE_WIDTH  memory read data, valid with pmem_resp.
REQ-019 SHALL have port grant_id  output  $clog2(NUM_CH)  index of channel currently owning memory.
REQ-020 SHALL have port busy  output  1  high while a transaction is outstanding.

Function
REQ-021 SHALL implement two states: IDLE, BUSY.
REQ-022 In IDLE with any ch_read|ch_write high, SHALL select one winner, register its index, address, wdata and op, and enter BUSY next edge.
REQ-023 SHALL drive pmem_read/pmem_write from registered op only in BUSY; request-to-memory latency exactly 1 cycle.
REQ-024 SHALL hold pmem_address, pmem_wdata, op and grant_id stable throughout BUSY regardless of channel input changes.
REQ-025 On pmem_resp in BUSY, SHALL assert ch_resp[grant_id] combinationally in the same cycle, pass pmem_rdata to ch_rdata, and return to IDLE next edge.
REQ-026 Round-robin: search starts at last granted index + 1, wrapping NUM_CH-1 -> 0; pointer updates on grant.
REQ-027 Fixed priority: lowest-index requesting channel wins.
REQ-028 A channel with both ch_read and ch_write high SHALL be served as a write.
REQ-029 pmem_resp in IDLE SHALL be ignored; no ch_resp.
REQ-030 Channel dropping its request during BUSY SHALL NOT abort; transaction completes and ch_resp still pulses to it.
REQ-031 Minimum gap between back-to-back transactions SHALL be one IDLE cycle; pmem_read/write low in that cycle.
REQ-032 ch_rdata SHALL equal pmem_rdata at all times; ch_resp all-zero outside the response cycle.

Reset
REQ-033 rst_n low at an edge SHALL force IDLE, pmem_read=0, pmem_write=0, ch_resp=0, busy=0, grant_id=0, pmem_address=0, pmem_wdata=0.
REQ-034 Reset SHALL set the round-robin pointer to NUM_CH-1 so channel 0 wins first.
REQ-035 Reset during BUSY SHALL discard the transaction; a later pmem_resp SHALL produce no ch_resp.

Verification
REQ-036 Single read: ch_read=01, addr0=0x1230, pmem_resp after 3 cycles with rdata=0xA5.. -> pmem_read high cycle+1, ch_resp=01 same cycle as pmem_resp, ch_rdata=0xA5...
REQ-037 Contention, round-robin: both channels request continuously -> grants alternate 0,1,0,1; each ch_resp one cycle.
REQ-038 Fixed priority FIXED_PRIO=1, NUM_CH=4, channels 1 and 3 request -> channel 1 served first, then 3.
REQ-039 Write: ch_write[1]=1, addr=0xBEE0, wdata=0xDEAD.. -> pmem_write=1, pmem_address=0xBEE0, pmem_wdata=0xDEAD.., ch_resp=10.
REQ-040 Reset in BUSY: rst_n low for one cycle mid-transaction, then pmem_resp -> no ch_resp, busy=0, next grant to channel 0.
